// File: rtl/memseq_pkg.sv
// ============================================================================
// Module : memseq_pkg
// Brief  : Shared types and constants for the memory access sequencer:
//          FSM state encoding, requester identifiers and the default
//          memory read latency.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package memseq_pkg;

    // Default number of memory read wait cycles (legal range 1..7).
    localparam int c_read_lat_default = 2;

    // Width of the read wait counter; holds READ_LAT-1, so at most 6.
    localparam int c_cnt_w = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_WR      = 2'd2,
        ST_RESP    = 2'd3
    } state_t;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_LS = 1'b1
    } req_id_t;

endpackage

`default_nettype wire

// File: rtl/memseq_rr_arb.sv
// ============================================================================
// Module : memseq_rr_arb
// Brief  : Two-way round-robin arbiter between the fetch (IF) and load/store
//          (LS) requesters. Grants are combinational while i_enable is high;
//          the last-granted register advances only when a grant is issued.
// Ports  : clock, reset      - clock, synchronous active-high reset
//          i_enable          - sequencer can accept a transaction this cycle
//          i_if_req/i_ls_req - request levels
//          o_if_gnt/o_ls_gnt - one-hot grant (both 0 when disabled)
//          o_winner          - requester selected by the round-robin decision
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module memseq_rr_arb
    import memseq_pkg::*;
(
    input  logic    clock,
    input  logic    reset,
    input  logic    i_enable,
    input  logic    i_if_req,
    input  logic    i_ls_req,
    output logic    o_if_gnt,
    output logic    o_ls_gnt,
    output req_id_t o_winner
);

    req_id_t r_last;
    req_id_t w_winner;

    // Under contention the requester that did not win last time goes next;
    // a lone requester always wins.
    always_comb begin
        w_winner = REQ_IF;
        if (i_if_req && i_ls_req) begin
            if (r_last == REQ_IF) begin
                w_winner = REQ_LS;
            end else begin
                w_winner = REQ_IF;
            end
        end else if (i_ls_req) begin
            w_winner = REQ_LS;
        end
    end

    assign o_if_gnt = i_enable && i_if_req && (w_winner == REQ_IF);
    assign o_ls_gnt = i_enable && i_ls_req && (w_winner == REQ_LS);
    assign o_winner = w_winner;

    // Resetting to IF hands the first contended grant to LS.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_last <= REQ_IF;
        end else if (o_if_gnt || o_ls_gnt) begin
            r_last <= w_winner;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_access_sequencer.sv
// ============================================================================
// Module : mem_access_sequencer
// Brief  : Serialises fetch reads and load/store accesses onto one memory
//          port. IDLE grants one requester (round-robin), then RD_WAIT for
//          READ_LAT cycles or WR for one cycle, then RESP pulses the owner's
//          done and returns to IDLE.
// Ports  : clock, reset                 - clock, synchronous active-high reset
//          if_req/if_addr/if_gnt/if_done - fetch port (always reads)
//          ls_req/ls_we/ls_addr/ls_wdata/ls_gnt/ls_done - load/store port
//          rdata                        - registered read data
//          mem_addr/mem_wr/mem_wdata/mem_rdata - memory port
//          busy, state_out              - status
//          stall_cnt                    - only with MEMSEQ_PERF_CNT_EN: cycles
//                                         with a request pending but no grant,
//                                         saturating at 16'hFFFF
// Config : `define MEMSEQ_PERF_CNT_EN to add the stall counter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_access_sequencer
    import memseq_pkg::*;
#(
    parameter int READ_LAT = c_read_lat_default
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_done,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_gnt,
    output logic        ls_done,
    output logic [31:0] rdata,
    output logic [31:0] mem_addr,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic [1:0]  state_out
`ifdef MEMSEQ_PERF_CNT_EN
    ,
    output logic [15:0] stall_cnt
`endif
);

    localparam logic [c_cnt_w-1:0] c_lat_m1 = c_cnt_w'(READ_LAT - 1);

    state_t               r_state;
    state_t               w_next_state;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [31:0]          r_addr;
    logic [31:0]          r_wdata;
    logic [31:0]          r_rdata;
    req_id_t              r_owner;

    logic                 w_if_gnt;
    logic                 w_ls_gnt;
    req_id_t              w_winner;
    logic                 w_accept;
    logic                 w_sel_we;
    logic [31:0]          w_sel_addr;
    logic                 w_rd_last;
    logic                 w_mem_wr;
    logic                 w_busy;
    logic                 w_if_done;
    logic                 w_ls_done;

    // Reset gates the grant so nothing is accepted while reset is held.
    memseq_rr_arb u_arb (
        .clock    (clock),
        .reset    (reset),
        .i_enable ((r_state == ST_IDLE) && !reset),
        .i_if_req (if_req),
        .i_ls_req (ls_req),
        .o_if_gnt (w_if_gnt),
        .o_ls_gnt (w_ls_gnt),
        .o_winner (w_winner)
    );

    assign w_accept   = w_if_gnt || w_ls_gnt;
    // The fetch port never writes, whatever ls_we happens to be.
    assign w_sel_we   = (w_winner == REQ_LS) ? ls_we : 1'b0;
    assign w_sel_addr = (w_winner == REQ_LS) ? ls_addr : if_addr;
    assign w_rd_last  = (r_state == ST_RD_WAIT) && (r_cnt == '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_owner <= REQ_IF;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_addr  <= w_sel_addr;
                r_owner <= w_winner;
                r_cnt   <= c_lat_m1;
                if (w_winner == REQ_LS) begin
                    r_wdata <= ls_wdata;
                end
            end else if ((r_state == ST_RD_WAIT) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_rd_last) begin
                r_rdata <= mem_rdata;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_mem_wr     = 1'b0;
        w_busy       = 1'b1;
        w_if_done    = 1'b0;
        w_ls_done    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_busy = 1'b0;
                if (w_accept) begin
                    w_next_state = w_sel_we ? ST_WR : ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (w_rd_last) begin
                    w_next_state = ST_RESP;
                end
            end
            ST_WR: begin
                w_mem_wr     = 1'b1;
                w_next_state = ST_RESP;
            end
            ST_RESP: begin
                w_if_done    = (r_owner == REQ_IF);
                w_ls_done    = (r_owner == REQ_LS);
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign if_gnt    = w_if_gnt;
    assign ls_gnt    = w_ls_gnt;
    assign if_done   = w_if_done;
    assign ls_done   = w_ls_done;
    assign rdata     = r_rdata;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_wr    = w_mem_wr;
    assign busy      = w_busy;
    assign state_out = r_state;

`ifdef MEMSEQ_PERF_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if ((if_req || ls_req) && !w_accept && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_access_sequencer.sv
// ============================================================================
// Module : tb_mem_access_sequencer
// Brief  : Self-checking bench for mem_access_sequencer. A scoreboard queues
//          the expected completion (cycle and data) and memory writes at
//          each grant and retires them as done pulses / write strobes appear.
//          A second instance with READ_LAT=1 covers back-to-back fetches.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_access_sequencer;

    localparam int          c_read_lat = 2;
    localparam logic [31:0] c_mem_key  = 32'h8C01_0044;

    logic        clock = 1'b0;
    logic        reset;
    logic        if_req, ls_req, ls_we;
    logic [31:0] if_addr, ls_addr, ls_wdata;
    logic        if_gnt, if_done, ls_gnt, ls_done;
    logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic        mem_wr, busy;
    logic [1:0]  state_out;

    logic        b_reset, b_if_req;
    logic [31:0] b_if_addr;
    logic        b_if_gnt, b_if_done, b_ls_gnt, b_ls_done, b_mem_wr, b_busy;
    logic [31:0] b_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic [1:0]  b_state_out;
`ifdef MEMSEQ_PERF_CNT_EN
    logic [15:0] stall_cnt, b_stall_cnt;
`endif

    always #5 clock = ~clock;

    // Memory model: read data is a fixed function of the address.
    assign mem_rdata   = mem_addr ^ c_mem_key;
    assign b_mem_rdata = b_mem_addr ^ c_mem_key;

    mem_access_sequencer #(.READ_LAT(c_read_lat)) u_dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_gnt(ls_gnt), .ls_done(ls_done), .rdata(rdata),
        .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .state_out(state_out)
`ifdef MEMSEQ_PERF_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    mem_access_sequencer #(.READ_LAT(1)) u_dut_b2b (
        .clock(clock), .reset(b_reset),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt), .if_done(b_if_done),
        .ls_req(1'b0), .ls_we(1'b0), .ls_addr(32'd0), .ls_wdata(32'd0),
        .ls_gnt(b_ls_gnt), .ls_done(b_ls_done), .rdata(b_rdata),
        .mem_addr(b_mem_addr), .mem_wr(b_mem_wr), .mem_wdata(b_mem_wdata),
        .mem_rdata(b_mem_rdata), .busy(b_busy), .state_out(b_state_out)
`ifdef MEMSEQ_PERF_CNT_EN
        , .stall_cnt(b_stall_cnt)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    typedef struct { logic [31:0] data; int due; logic is_rd; } rsp_t;
    typedef struct { logic [31:0] addr; logic [31:0] data; int due; } wr_t;

    rsp_t q_if[$];
    rsp_t q_ls[$];
    wr_t  q_wr[$];
    rsp_t e_rsp;
    wr_t  e_wr;

    always @(posedge clock) cyc <= cyc + 1;

    // Scoreboard: retire completions first, then queue new grants.
    always @(negedge clock) begin
        if (reset) begin
            q_if.delete();
            q_ls.delete();
            q_wr.delete();
        end else begin
            check("gnt_excl", 32'(if_gnt & ls_gnt), 32'd0);
            if (state_out != 2'd0) check("gnt_not_idle", 32'(if_gnt | ls_gnt), 32'd0);

            if (q_if.size() == 0) check("if_done_unexp", 32'(if_done), 32'd0);
            else if (if_done) begin
                e_rsp = q_if.pop_front();
                check("if_done_cyc", 32'(cyc), 32'(e_rsp.due));
                check("if_rdata", rdata, e_rsp.data);
            end else if (cyc >= q_if[0].due) begin
                check("if_done_miss", 32'(if_done), 32'd1);
                void'(q_if.pop_front());
            end

            if (q_ls.size() == 0) check("ls_done_unexp", 32'(ls_done), 32'd0);
            else if (ls_done) begin
                e_rsp = q_ls.pop_front();
                check("ls_done_cyc", 32'(cyc), 32'(e_rsp.due));
                if (e_rsp.is_rd) check("ls_rdata", rdata, e_rsp.data);
            end else if (cyc >= q_ls[0].due) begin
                check("ls_done_miss", 32'(ls_done), 32'd1);
                void'(q_ls.pop_front());
            end

            if (q_wr.size() == 0) check("mem_wr_unexp", 32'(mem_wr), 32'd0);
            else if (mem_wr) begin
                e_wr = q_wr.pop_front();
                check("mem_wr_cyc", 32'(cyc), 32'(e_wr.due));
                check("mem_wr_addr", mem_addr, e_wr.addr);
                check("mem_wr_data", mem_wdata, e_wr.data);
            end else if (cyc >= q_wr[0].due) begin
                check("mem_wr_miss", 32'(mem_wr), 32'd1);
                void'(q_wr.pop_front());
            end

            if (if_gnt) q_if.push_back('{data: if_addr ^ c_mem_key, due: cyc + c_read_lat + 1, is_rd: 1'b1});
            if (ls_gnt) begin
                if (ls_we) begin
                    q_wr.push_back('{addr: ls_addr, data: ls_wdata, due: cyc + 1});
                    q_ls.push_back('{data: 32'd0, due: cyc + 2, is_rd: 1'b0});
                end else begin
                    q_ls.push_back('{data: ls_addr ^ c_mem_key, due: cyc + c_read_lat + 1, is_rd: 1'b1});
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drain(input int max);
        int k = 0;
        while (((q_if.size() + q_ls.size() + q_wr.size()) != 0 || busy) && k < max) begin
            step();
            k++;
        end
        @(negedge clock);
        check("drain", 32'(q_if.size() + q_ls.size() + q_wr.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         ng;
        int         tb_stall;
        logic [3:0] exp_ls_order;
        int         gc[$];
        logic       b_seen;

        reset = 1'b1; if_req = 1'b1; if_addr = 32'h0;
        ls_req = 1'b0; ls_we = 1'b0; ls_addr = 32'h0; ls_wdata = 32'h0;
        b_reset = 1'b1; b_if_req = 1'b0; b_if_addr = 32'h0;
        repeat (3) step();

        // Reset state, with a fetch request held to show grants are blocked.
        @(negedge clock);
        check("rst_state", 32'(state_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_if_gnt", 32'(if_gnt), 32'd0);
        check("rst_ls_gnt", 32'(ls_gnt), 32'd0);
        check("rst_mem_wr", 32'(mem_wr), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_rdata", rdata, 32'd0);
`ifdef MEMSEQ_PERF_CNT_EN
        check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
        if_req = 1'b0;
        step();
        reset = 1'b0;

        // Single fetch read from 0x40.
        step();
        if_req = 1'b1; if_addr = 32'h40;
        @(negedge clock);
        check("fetch_gnt", 32'(if_gnt), 32'd1);
        step();
        if_req = 1'b0;
        @(negedge clock);
        check("fetch_c1_state", 32'(state_out), 32'd1);
        check("fetch_c1_addr", mem_addr, 32'h40);
        check("fetch_c1_busy", 32'(busy), 32'd1);
        step();
        @(negedge clock);
        check("fetch_c2_addr", mem_addr, 32'h40);
        check("fetch_c2_wr", 32'(mem_wr), 32'd0);
        step();
        @(negedge clock);
        check("fetch_c3_done", 32'(if_done), 32'd1);
        check("fetch_c3_rdata", rdata, 32'h8C01_0004);
        step();
        @(negedge clock);
        check("fetch_c4_state", 32'(state_out), 32'd0);
        check("fetch_c4_addr_hold", mem_addr, 32'h40);

        // Store 0xDEADBEEF to 0x100.
        step();
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h100; ls_wdata = 32'hDEAD_BEEF;
        @(negedge clock);
        check("store_gnt", 32'(ls_gnt), 32'd1);
        step();
        ls_req = 1'b0;
        @(negedge clock);
        check("store_c1_wr", 32'(mem_wr), 32'd1);
        check("store_c1_addr", mem_addr, 32'h100);
        check("store_c1_data", mem_wdata, 32'hDEAD_BEEF);
        step();
        @(negedge clock);
        check("store_c2_done", 32'(ls_done), 32'd1);
        check("store_c2_wr", 32'(mem_wr), 32'd0);

        // Load through the LS port.
        step();
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h200;
        @(negedge clock);
        step();
        ls_req = 1'b0;
        drain(20);

        // Contention after reset: LS (store) first, then alternating.
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h300; ls_wdata = 32'h1234_5678;
        if_req = 1'b1; if_addr = 32'h44;
        exp_ls_order = 4'b0101;
        ng = 0;
        tb_stall = 0;
        for (int k = 0; k < 40 && ng < 4; k++) begin
            @(negedge clock);
            if (if_gnt || ls_gnt) begin
                check("rr_order", 32'(ls_gnt), 32'(exp_ls_order[ng]));
                ng++;
            end else begin
                tb_stall++;
            end
            if (ng < 4) step();
        end
        check("rr_grants", 32'(ng), 32'd4);
        step();
        if_req = 1'b0; ls_req = 1'b0;
        drain(20);
        // Busy cycles between the four grants: store, read, store.
        check("rr_wait_cycles", 32'(tb_stall), 32'(2 + (c_read_lat + 1) + 2));
`ifdef MEMSEQ_PERF_CNT_EN
        check("stall_cnt", 32'(stall_cnt), 32'(2 + (c_read_lat + 1) + 2));
`endif

        // Reset during RD_WAIT aborts the read.
        step();
        if_req = 1'b1; if_addr = 32'h80;
        @(negedge clock);
        check("abort_gnt", 32'(if_gnt), 32'd1);
        step();
        if_req = 1'b0;
        @(negedge clock);
        check("abort_rdwait", 32'(state_out), 32'd1);
        reset = 1'b1;
        step();
        @(negedge clock);
        check("abort_state", 32'(state_out), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_mem_wr", 32'(mem_wr), 32'd0);
        reset = 1'b0;
        repeat (4) begin
            step();
            @(negedge clock);
            check("abort_no_done", 32'(if_done | ls_done), 32'd0);
        end
        step();
        if_req = 1'b1; if_addr = 32'hC0;
        @(negedge clock);
        check("after_abort_gnt", 32'(if_gnt), 32'd1);
        step();
        if_req = 1'b0;
        drain(20);

        // Back-to-back fetches with READ_LAT=1 on the second instance.
        step();
        b_reset = 1'b0;
        b_if_req = 1'b1; b_if_addr = 32'h500;
        b_seen = 1'b0;
        for (int k = 0; k < 30 && gc.size() < 4; k++) begin
            @(negedge clock);
            if (b_if_done && !b_seen && gc.size() > 0) begin
                b_seen = 1'b1;
                check("b2b_done_lat", 32'(cyc - gc[0]), 32'd2);
                check("b2b_rdata", b_rdata, 32'h500 ^ c_mem_key);
            end
            if (b_if_gnt) gc.push_back(cyc);
            if (gc.size() < 4) step();
        end
        check("b2b_grants", 32'(gc.size()), 32'd4);
        check("b2b_done_seen", 32'(b_seen), 32'd1);
        if (gc.size() == 4) begin
            for (int i = 1; i < 4; i++) check("b2b_spacing", 32'(gc[i] - gc[i-1]), 32'd3);
        end
        step();
        b_if_req = 1'b0;

        repeat (4) step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_access_sequencer.md
MEM_ACCESS_SEQUENCER -- requirements
Module: mem_access_sequencer

Interface
REQ-001 Parameter: READ_LAT, 2, memory read wait cycles (legal 1..7).
REQ-002 Clocking: one clock; reset is synchronous and active-high; ports named clock and reset.
REQ-003 clock  in  1  rising-edge clock.
REQ-004 reset  in  1  synchronous active-high reset.
REQ-005 if_req  in  1  fetch read request (level).
REQ-006 if_addr  in  32  fetch byte address.
REQ-007 if_gnt  out  1  fetch request accepted this cycle.
REQ-008 if_done  out  1  one-cycle pulse, fetch data valid.
REQ-009 ls_req  in  1  load/store request (level).
REQ-010 ls_we  in  1  1 = store, 0 = load.
REQ-011 ls_addr, ls_wdata  in  32 each  load/store address, store data.
REQ-012 ls_gnt, ls_done  out  1 each  accept, completion pulse.
REQ-013 rdata  out  32  registered read data, valid while if_done or ls_done is high.
REQ-014 mem_addr  out  32  memory address; mem_wr  out  1  memory write strobe (1 = write); mem_wdata  out  32.
REQ-015 mem_rdata  in  32  memory read data.
REQ-016 busy  out  1  high in every state except IDLE; state_out  out  2  current state encoding.

Function
REQ-017 The FSM SHALL have the states IDLE, RD_WAIT, WR and RESP.
REQ-018 In IDLE, the gnt SHALL be combinational: the winning requester with req=1 gets gnt=1, and the transaction is accepted on the same edge.
REQ-019 Arbitration SHALL be 2-way round-robin: when both requesters assert req, the requester not granted last wins; a lone requester always wins.
REQ-020 On accept: addr, we and wdata SHALL be captured; the next state SHALL be RD_WAIT for reads and WR for stores; the wait counter SHALL load READ_LAT-1.
REQ-021 RD_WAIT SHALL last exactly READ_LAT cycles with mem_wr=0; mem_rdata SHALL be sampled into rdata on its last cycle.
REQ-022 WR SHALL last exactly 1 cycle with mem_wr=1, driving the captured mem_addr and mem_wdata.
REQ-023 RESP SHALL last 1 cycle, pulse the owner's done, then return to IDLE.
REQ-024 Latency from accept edge to done: READ_LAT+1 cycles for reads, 2 cycles for stores.
REQ-025 No gnt SHALL be asserted outside IDLE; a req held through RESP is granted no earlier than the following IDLE cycle.
REQ-026 mem_addr SHALL hold the last captured address in IDLE; mem_wr SHALL be 0 in every state except WR.
REQ-027 A fetch with ls_we=1 present is impossible; the fetch port SHALL always read.

Reset
REQ-028 Reset SHALL produce: state IDLE, counter 0, last-granted = fetch (so the first contended grant goes to ls), mem_addr/mem_wdata/rdata 0, and all gnt/done/mem_wr/busy 0.
REQ-029 Reset mid-transaction SHALL abort the access: no done pulse is issued, and mem_wr is 0 from the first cycle after the reset edge.

Configuration
REQ-030 With MEMSEQ_PERF_CNT_EN defined, output stall_cnt (out, 16) SHALL count cycles in which any req=1 and no gnt=1, saturating at 16'hFFFF; reset clears it.
REQ-031 Without MEMSEQ_PERF_CNT_EN, the stall_cnt port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-032 Package memseq_pkg SHALL hold: the state enum, the requester-id enum (REQ_IF, REQ_LS), and the READ_LAT default constant.
REQ-033 The round-robin decision and the last-granted register SHALL live in sub-module memseq_rr_arb.

Verification
REQ-034 Single fetch read, READ_LAT=2, if_addr=0x40, mem returns 0x8C010004 -> if_gnt at cycle 0; mem_addr=0x40 for cycles 1-2; if_done=1 and rdata=0x8C010004 at cycle 3.
REQ-035 Store: ls_we=1, addr=0x100, wdata=0xDEADBEEF -> mem_wr=1 only in cycle 1 with that addr/data; ls_done at cycle 2.
REQ-036 Both requesters asserted at once after reset -> ls granted first; with both held, the next grant goes to if, then ls, alternating.
REQ-037 Reset asserted during RD_WAIT -> next cycle state IDLE, busy=0, no done; a subsequent request completes normally.
REQ-038 Back-to-back fetch with if_req held high, READ_LAT=1 -> grants spaced exactly 3 cycles apart; with MEMSEQ_PERF_CNT_EN, contention test stall_cnt matches the count of waiting cycles.
